// File: rtl/fib_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock: done pulses WIDTH+1 edges after start.
// No backpressure: start is accepted only when idle and ignored while busy; bcd holds until the next completion.
module fib_bcd #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 7,
    parameter int CW     = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [4*DIGITS-1:0] scr_q, scr_d, corr;
    logic [4*DIGITS-1:0] bcd_q;
    logic [CW-1:0]       cnt_q;
    logic                busy_q, done_q;

    // Add-3 on each digit first, then shift the binary MSB into the scratch LSB.
    always_comb begin
        corr = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        scr_d = (corr << 1) | {{(4*DIGITS-1){1'b0}}, bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        bin_q   <= bin;
                        scr_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    scr_q <= scr_d;
                    bin_q <= bin_d;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        bcd_q   <= scr_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

    a_start_known: assert property (@(posedge clk) disable iff (!rst)
        (state_q == IDLE) |-> !$isunknown(start));

endmodule

// File: tb/tb_fib_bcd.sv
module tb_fib_bcd;
    localparam int WIDTH  = 20;
    localparam int DIGITS = 7;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [WIDTH-1:0]    bin = '0;
    logic                busy, done;
    logic [4*DIGITS-1:0] bcd;

    int checks = 0, errors = 0, done_cnt = 0;
    logic [4*DIGITS-1:0] exp_q[$];

    fib_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .bin(bin), .start(start),
        .busy(busy), .done(done), .bcd(bcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [WIDTH-1:0] fib_ref(input int n);
        int a = 0, b = 1, t;
        for (int i = 0; i < n; i++) begin
            t = a + b; a = b; b = t;
        end
        return WIDTH'(a);
    endfunction

    function automatic logic [4*DIGITS-1:0] bcd_ref(input int v);
        logic [4*DIGITS-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got pulse with bcd %h, expected none", bcd);
            end else begin
                chk("bcd_result", 32'(bcd), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0) begin
            if (t >= 100) begin
                chk("idle_timeout", 32'(busy), 32'd0);
                return;
            end
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run_conv(input logic [WIDTH-1:0] b, input logic [4*DIGITS-1:0] exp,
                            input logic [4*DIGITS-1:0] hold, input bit chk_hold, input bit chk_lat);
        int busy_n = 0, done_at = 0;
        wait_idle();
        @(negedge clk);
        bin = b;
        start = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        bin = WIDTH'($urandom);
        for (int k = 1; k <= 60; k++) begin
            if (busy !== 1'b1) break;
            busy_n++;
            if (done === 1'b1 && done_at == 0) done_at = k;
            if (chk_hold && done !== 1'b1) chk("bcd_hold", 32'(bcd), 32'(hold));
            @(negedge clk);
        end
        if (chk_lat) begin
            chk("done_latency", done_at, WIDTH + 1);
            chk("busy_cycles", busy_n, WIDTH + 1);
        end
        chk("bcd_held_idle", 32'(bcd), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [WIDTH-1:0] v;

        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_conv(20'd0, 28'h0000000, 28'h0, 1'b0, 1'b1);
        run_conv(20'd34, 28'h0000034, 28'h0, 1'b0, 1'b1);
        run_conv(20'd6765, 28'h0006765, 28'h0000034, 1'b1, 1'b0);
        run_conv(20'd1048575, 28'h1048575, 28'h0, 1'b0, 1'b1);
        run_conv(20'd999999, 28'h0999999, 28'h0, 1'b0, 1'b0);

        // Second start 5 cycles into a conversion must be ignored.
        wait_idle();
        base = done_cnt;
        @(negedge clk);
        bin = 20'd1234;
        start = 1'b1;
        exp_q.push_back(28'h0001234);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        bin = 20'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (25) @(negedge clk);
        chk("ignored_start_dones", done_cnt - base, 1);
        chk("ignored_start_bcd", 32'(bcd), 32'h0001234);

        // Asynchronous reset mid-conversion discards the partial result.
        @(negedge clk);
        bin = 20'd832040;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_conv(20'd832040, 28'h0832040, 28'h0, 1'b0, 1'b1);

        // Fibonacci values as fib would deliver them.
        base = done_cnt;
        for (int i = 0; i < 10; i++) begin
            v = fib_ref(int'($urandom_range(0, 29)));
            run_conv(v, bcd_ref(int'(v)), 28'h0, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        chk("chain_done_count", done_cnt - base, 10);
        chk("queue_empty", exp_q.size(), 0);
        chk("total_dones", done_cnt, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
